// File: rtl/div_clk_monitor.sv
// Measures a divided clock over a fixed window of clk cycles: rising-edge count, high-sample count, range/stuck flags.
// Define DIV_CLK_MONITOR_SYNC_EN to insert a 2-flop synchronizer ahead of the sample register.
//
// state   | meaning
// IDLE    | waiting for start, previous results held
// ARM     | preload prev sample, clear accumulators and window counter
// MEASURE | accumulate edges/high samples for WINDOW cycles
// REPORT  | result_valid high until result_ack
module div_clk_monitor #(
    parameter int WINDOW  = 70,
    parameter int EXP_MIN = 10,
    parameter int EXP_MAX = 10,
    parameter int CNT_W   = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div_in,
    input  logic             start,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ack,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             in_range,
    output logic             stuck
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

    state_t           state;
    logic             s;
    logic             prev;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_acc;
    logic [CNT_W-1:0] high_acc;
    logic [CNT_W-1:0] edge_nxt;
    logic [CNT_W-1:0] high_nxt;

`ifdef DIV_CLK_MONITOR_SYNC_EN
    logic [1:0] sync_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
            s       <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], clk_div_in};
            s       <= sync_ff[1];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) s <= 1'b0;
        else     s <= clk_div_in;
    end
`endif

    // Values including the current cycle's contribution, so the final cycle loads complete totals.
    always_comb begin
        edge_nxt = edge_acc + CNT_W'(s & ~prev);
        high_nxt = high_acc + CNT_W'(s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            edge_cnt     <= '0;
            high_cnt     <= '0;
            in_range     <= 1'b0;
            stuck        <= 1'b0;
            prev         <= 1'b0;
            win_cnt      <= '0;
            edge_acc     <= '0;
            high_acc     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    prev     <= s;
                    edge_acc <= '0;
                    high_acc <= '0;
                    win_cnt  <= '0;
                    state    <= MEASURE;
                end
                MEASURE: begin
                    edge_acc <= edge_nxt;
                    high_acc <= high_nxt;
                    prev     <= s;
                    win_cnt  <= win_cnt + 1'b1;
                    if (win_cnt == WIN_LAST) begin
                        edge_cnt     <= edge_nxt;
                        high_cnt     <= high_nxt;
                        in_range     <= (32'(edge_nxt) >= EXP_MIN) && (32'(edge_nxt) <= EXP_MAX);
                        stuck        <= (edge_nxt == '0);
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        state        <= REPORT;
                    end
                end
                REPORT: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: directed sequence with randomized divided-clock patterns,
// checked against a sample-history reference model.
module tb_div_clk_monitor;
    localparam int W    = 70;
    localparam int EMIN = 10;
    localparam int EMAX = 10;
    localparam int CW   = $clog2(W + 1);
`ifdef DIV_CLK_MONITOR_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_div_in = 1'b0;
    logic          start = 1'b0;
    logic          result_ack = 1'b0;
    logic          busy, result_valid, in_range, stuck;
    logic [CW-1:0] edge_cnt, high_cnt;

    int   vectors = 0;
    int   miscompares = 0;
    logic hist[$];
    int   mode = 1;
    logic cval = 1'b0;
    int   per = 5;
    int   hi_len = 2;
    int   ph = 0;
    int   exp_e, exp_h;

    div_clk_monitor #(.WINDOW(W), .EXP_MIN(EMIN), .EXP_MAX(EMAX)) dut (
        .clk(clk), .rst(rst), .clk_div_in(clk_div_in), .start(start),
        .busy(busy), .result_valid(result_valid), .result_ack(result_ack),
        .edge_cnt(edge_cnt), .high_cnt(high_cnt), .in_range(in_range), .stuck(stuck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One clk cycle: drive the next pin value, record what the edge sees, sample 1 ns later.
    task automatic step();
        case (mode)
            0:       clk_div_in = cval;
            1: begin clk_div_in = ((ph % per) < hi_len); ph++; end
            default: clk_div_in = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk);
        hist.push_back(clk_div_in);
        #1;
    endtask

    // Window = the W pin values seen at the edges after the start edge, delayed by the sync depth;
    // the value just before the window is the reference for the first edge.
    task automatic model(input int te);
        logic p, v;
        exp_e = 0;
        exp_h = 0;
        p = hist[te - D];
        for (int i = 1; i <= W; i++) begin
            v = hist[te + i - D];
            if (v && !p) exp_e++;
            if (v) exp_h++;
            p = v;
        end
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_edge"},  edge_cnt, exp_e);
        chk({tag, "_high"},  high_cnt, exp_h);
        chk({tag, "_range"}, in_range, (exp_e >= EMIN && exp_e <= EMAX) ? 1 : 0);
        chk({tag, "_stuck"}, stuck, (exp_e == 0) ? 1 : 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_edge"},  edge_cnt, 0);
        chk({tag, "_high"},  high_cnt, 0);
        chk({tag, "_range"}, in_range, 0);
        chk({tag, "_stuck"}, stuck, 0);
    endtask

    // Pulse start, optionally re-pulse it 'poke' cycles later, wait for result_valid.
    task automatic measure(input string tag, input int poke);
        int te, n;
        start = 1'b1;
        step();
        start = 1'b0;
        te = hist.size() - 1;
        chk({tag, "_busy"}, busy, 1);
        n = 0;
        while (!result_valid && n < W + 20) begin
            start = (n == poke);
            step();
            start = 1'b0;
            n++;
        end
        chk({tag, "_valid"}, result_valid, 1);
        chk({tag, "_latency"}, n + 1, W + 2);
        model(te);
        check_results(tag);
    endtask

    task automatic ack_after(input string tag, input int dly);
        repeat (dly) begin
            step();
            chk({tag, "_hold_valid"}, result_valid, 1);
            chk({tag, "_hold_edge"}, edge_cnt, exp_e);
            chk({tag, "_hold_high"}, high_cnt, exp_h);
        end
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk({tag, "_drop"}, result_valid, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_retain"}, edge_cnt, exp_e);
    endtask

    initial begin
        // Reset while the input toggles
        mode = 1; per = 5; hi_len = 2; ph = 0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check_zero("reset");
        repeat (5) begin
            step();
            chk("reset_no_valid", result_valid, 0);
            chk("reset_no_busy", busy, 0);
        end

        // Nominal ratio 7 (4 high / 3 low)
        per = 7; hi_len = 4; ph = 0;
        measure("nom", -1);
        chk("nom_edge10", edge_cnt, 10);
        chk("nom_high40", high_cnt, 40);
        chk("nom_inrange", in_range, 1);
        ack_after("nom_ack", 2);
        ph = ph + int'($urandom_range(1, 6));
        measure("nom_shift", -1);
        chk("nom_shift_edge10", edge_cnt, 10);
        chk("nom_shift_high40", high_cnt, 40);
        ack_after("nom_shift_ack", 2);

        // Period 8 is out of range
        per = 8; hi_len = 4; ph = $urandom_range(0, 7);
        measure("p8", -1);
        chk("p8_out_of_range", in_range, 0);
        ack_after("p8_ack", 1);

        // Stuck high
        mode = 0; cval = 1'b1;
        repeat (4) step();
        measure("stuck", -1);
        chk("stuck_edge0", edge_cnt, 0);
        chk("stuck_high70", high_cnt, W);
        chk("stuck_flag", stuck, 1);
        ack_after("stuck_ack", 1);

        // Handshake: long hold, start during busy, start coinciding with ack in REPORT
        mode = 2;
        measure("hs", 10);
        ack_after("hs_ack", 20);
        measure("hs2", -1);
        start = 1'b1; result_ack = 1'b1;
        step();
        start = 1'b0; result_ack = 1'b0;
        chk("hs2_drop", result_valid, 0);
        repeat (3) begin
            step();
            chk("hs2_no_rearm", busy, 0);
        end
        mode = 1; per = 7; hi_len = 4; ph = $urandom_range(0, 6);
        measure("hs_fresh", -1);
        chk("hs_fresh_edge10", edge_cnt, 10);
        ack_after("hs_fresh_ack", 0);

        // Reset at MEASURE cycle 30
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (31) step();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("mid_rst");
        step();
        chk("mid_idle", busy, 0);
        measure("mid_rerun", -1);
        chk("mid_rerun_edge10", edge_cnt, 10);
        ack_after("mid_rerun_ack", 1);

        // Randomized patterns
        for (int k = 0; k < 6; k++) begin
            mode = $urandom_range(1, 2);
            per = $urandom_range(2, 12);
            hi_len = $urandom_range(1, per - 1);
            ph = $urandom_range(0, per - 1);
            repeat (3) step();
            measure($sformatf("rnd%0d", k), -1);
            ack_after($sformatf("rnd%0d_ack", k), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
